// File: rtl/cla_slice_sequencer.sv
// Sequences a WIDTH-bit add through one external 8-bit CLA, one byte per clock, chaining carry in a register.
// Optional CLA_SEQ_SUB_EN adds a 'sub' input that turns the operation into op_a - op_b.
module cla_slice_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             cin,
`ifdef CLA_SEQ_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic [7:0]       add_a,
  output logic [7:0]       add_b,
  output logic             add_cin,
  input  logic [7:0]       add_sum,
  input  logic             add_cout,
  output logic [1:0]       dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; in_ready is high only in IDLE, out_valid only in DONE, and a
  // raised out_valid holds sum/cout stable until out_ready is seen.

  localparam int NSLICE = WIDTH / 8;
  localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IDXW-1:0] LAST = IDXW'(NSLICE - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q;
  logic [IDXW-1:0]  idx_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] sum_q;
  logic             carry_q;
  logic             cout_q;
  logic             in_ready_q;
  logic             out_valid_q;
  logic             sub_q;
  logic             sub_d;
  logic [7:0]       a_byte_d;
  logic [7:0]       b_byte_d;

`ifdef CLA_SEQ_SUB_EN
  assign sub_d = sub;
`else
  assign sub_d = 1'b0;
`endif

  always_comb begin
    a_byte_d = '0;
    b_byte_d = '0;
    for (int s = 0; s < NSLICE; s++) begin
      if (idx_q == IDXW'(s)) begin
        a_byte_d = a_q[8*s +: 8];
        b_byte_d = b_q[8*s +: 8];
      end
    end
  end

  // Adder inputs are forced to zero whenever no slice is in flight.
  assign add_a     = (state_q == BUSY) ? a_byte_d : 8'h00;
  assign add_b     = (state_q == BUSY) ? (sub_q ? ~b_byte_d : b_byte_d) : 8'h00;
  assign add_cin   = (state_q == BUSY) && carry_q;
  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign dbg_state = state_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      carry_q     <= 1'b0;
      cout_q      <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      sub_q       <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q        <= op_a;
            b_q        <= op_b;
            sub_q      <= sub_d;
            // Subtraction is a + ~b + 1, so the chain starts with carry set.
            carry_q    <= sub_d | cin;
            idx_q      <= '0;
            in_ready_q <= 1'b0;
            state_q    <= BUSY;
          end
        end
        BUSY: begin
          for (int s = 0; s < NSLICE; s++) begin
            if (idx_q == IDXW'(s)) sum_q[8*s +: 8] <= add_sum;
          end
          carry_q <= add_cout;
          if (idx_q == LAST) begin
            cout_q      <= add_cout;
            idx_q       <= '0;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          state_q     <= IDLE;
        end
      endcase
    end
  end

endmodule
